// File: rtl/dpll_loop_controller_if.sv
// Loop-filter link: correction pulses from the loop filter, K modulus control back to it.
interface dpll_loop_controller_if;
  logic       dlfCarry;
  logic       dlfBorrow;
  logic [3:0] kExp;
  logic       kLoad;

  modport master (input dlfCarry, input dlfBorrow, output kExp, output kLoad);
  modport slave  (output dlfCarry, output dlfBorrow, input kExp, input kLoad);
endinterface

// File: rtl/dpll_loop_controller.sv
// DPLL loop-gain scheduler and lock detector: counts loop-filter corrections per
// observation window, steps the K exponent up as the loop settles and flags lock.
module dpll_loop_controller #(
  parameter int K_MIN_EXP     = 2,
  parameter int K_MAX_EXP     = 8,
  parameter int WINDOW_BITS   = 10,
  parameter int LOCK_THRESH   = 4,
  parameter int UNLOCK_THRESH = 16,
  parameter int LOCK_WINDOWS  = 3
) (
  input  logic                   oscInput,
  input  logic                   reset,
  input  logic                   enable,
  dpll_loop_controller_if.master lf,
  output logic                   locked,
  output logic [1:0]             state,
  output logic [7:0]             corrCount
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  localparam logic [3:0] KMIN     = 4'(K_MIN_EXP);
  localparam logic [3:0] KMAX     = 4'(K_MAX_EXP);
  localparam logic [7:0] LOCK_T   = 8'(LOCK_THRESH);
  localparam logic [7:0] UNLOCK_T = 8'(UNLOCK_THRESH);
  localparam logic [7:0] LOCK_W   = 8'(LOCK_WINDOWS);

  state_t                 state_q, state_d;
  logic [3:0]             kexp_q, kexp_d;
  logic                   kload_q, kload_d;
  logic                   locked_q, locked_d;
  logic                   carry_q, carry_d;
  logic                   borrow_q, borrow_d;
  logic [7:0]             corr_q, corr_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [7:0]             quiet_q, quiet_d;
  logic [WINDOW_BITS-1:0] win_q, win_d;

  logic [1:0] ev_s;
  logic [8:0] sum_s;
  logic [7:0] csum_s;
  logic [7:0] quiet_inc_s;
  logic       eval_s, quiet_s, noisy_s;

  // This cycle's events are part of the window total, so evaluation sees them too.
  assign ev_s        = {1'b0, lf.dlfCarry & ~carry_q} + {1'b0, lf.dlfBorrow & ~borrow_q};
  assign sum_s       = {1'b0, cnt_q} + {7'd0, ev_s};
  assign csum_s      = sum_s[8] ? 8'hFF : sum_s[7:0];
  assign eval_s      = (win_q == {WINDOW_BITS{1'b1}});
  assign quiet_s     = (csum_s <= LOCK_T);
  assign noisy_s     = (csum_s > UNLOCK_T);
  assign quiet_inc_s = quiet_q + 8'd1;

  // State and output registers.
  always_ff @(posedge oscInput or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      kexp_q   <= KMIN;
      kload_q  <= 1'b0;
      locked_q <= 1'b0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      corr_q   <= 8'd0;
      cnt_q    <= 8'd0;
      quiet_q  <= 8'd0;
      win_q    <= {WINDOW_BITS{1'b0}};
    end else begin
      state_q  <= state_d;
      kexp_q   <= kexp_d;
      kload_q  <= kload_d;
      locked_q <= locked_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      corr_q   <= corr_d;
      cnt_q    <= cnt_d;
      quiet_q  <= quiet_d;
      win_q    <= win_d;
    end
  end

  // Next state: enable low wins, then start-up from IDLE, then per-window scheduling.
  always_comb begin
    state_d  = state_q;
    kexp_d   = kexp_q;
    kload_d  = 1'b0;
    locked_d = locked_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    corr_d   = corr_q;
    cnt_d    = cnt_q;
    quiet_d  = quiet_q;
    win_d    = win_q;
    if (!enable) begin
      // Edge registers sit at 0 outside a run so a level already high counts once at start.
      state_d  = IDLE;
      kexp_d   = KMIN;
      locked_d = 1'b0;
      carry_d  = 1'b0;
      borrow_d = 1'b0;
      cnt_d    = 8'd0;
      quiet_d  = 8'd0;
      win_d    = {WINDOW_BITS{1'b0}};
    end else if (state_q == IDLE) begin
      state_d = ACQUIRE;
      kexp_d  = KMIN;
      kload_d = 1'b1;
    end else begin
      carry_d  = lf.dlfCarry;
      borrow_d = lf.dlfBorrow;
      win_d    = win_q + WINDOW_BITS'(1);
      if (!eval_s) begin
        cnt_d = csum_s;
      end else begin
        cnt_d  = 8'd0;
        corr_d = csum_s;
        case (state_q)
          ACQUIRE: begin
            if (quiet_s) begin
              state_d = TRACK;
              kexp_d  = kexp_q + 4'd1;
              kload_d = 1'b1;
              quiet_d = 8'd0;
            end else begin
              state_d = ACQUIRE;
            end
          end
          TRACK: begin
            if (noisy_s) begin
              state_d = ACQUIRE;
              kexp_d  = KMIN;
              kload_d = 1'b1;
              quiet_d = 8'd0;
            end else if (quiet_s && (kexp_q < KMAX)) begin
              kexp_d  = kexp_q + 4'd1;
              kload_d = 1'b1;
              quiet_d = 8'd0;
            end else if (quiet_s) begin
              if (quiet_inc_s >= LOCK_W) begin
                state_d  = LOCKED;
                locked_d = 1'b1;
                quiet_d  = 8'd0;
              end else begin
                quiet_d = quiet_inc_s;
              end
            end else begin
              quiet_d = 8'd0;
            end
          end
          LOCKED: begin
            // Only a noisy window drops lock; moderate ones are absorbed.
            if (noisy_s) begin
              state_d  = ACQUIRE;
              locked_d = 1'b0;
              kexp_d   = KMIN;
              kload_d  = 1'b1;
              quiet_d  = 8'd0;
            end else begin
              state_d = LOCKED;
            end
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  assign lf.kExp   = kexp_q;
  assign lf.kLoad  = kload_q;
  assign locked    = locked_q;
  assign state     = state_q;
  assign corrCount = corr_q;
endmodule
